gene_network_stepper: RTL
=========================

// Module: gene_network_stepper
// PURPOSE
//  Boolean gene-regulatory-network update engine for the 8-gene network; sits directly upstream of
//  the fixed-point checker. On start it loads an initial state, then computes x[t+1] = F(x[t]) once
//  per clock. It drives x and a run tag (init_val_chk) into the checker and stops when the checker
//  returns fp_flag or the step budget runs out.
// PARAMETERS
//  ACT_MASK   64'h4020100804020180  gene i activators = bits [8i+7:8i]; default ring: gene i <- gene i-1
//  INH_MASK   64'h0                 gene i inhibitors = bits [8i+7:8i]
//  STEP_W     8                     width of step_cnt
//  MAX_STEPS  255                   step budget per run; must be 1..2^STEP_W-1
// PORTS
//  clk           in   1       clock; all state updates on posedge
//  rst           in   1       synchronous, active-high reset
//  start         in   1       run request; accepted only in IDLE or DONE
//  init_val      in   8       initial gene state; sampled when start is accepted
//  fp_flag       in   1       fixed-point flag returned by the downstream checker
//  x             out  8       current gene state x[t], registered
//  init_val_chk  out  8       run tag; increments (mod 256) on each accepted start
//  busy          out  1       1 while in LOAD or RUN
//  done          out  1       1 while in DONE (level)
//  fixed         out  1       run ended on a qualified fp_flag
//  timeout       out  1       run ended on the step budget
//  step_cnt      out  STEP_W  updates applied in the current/last run
// BEHAVIOUR
//  Reset: state=IDLE; x, init_val_chk, step_cnt = 0; busy, done, fixed, timeout = 0. Reset wins over
//   all other inputs and aborts any run mid-operation.
//  Update rule per gene i: a = |(x & ACT_i); r = |(x & INH_i); x_next[i] = a & ~r.
//   ACT_i = 0 gives a constant 0.
//  FSM: IDLE -> LOAD -> RUN -> DONE.
//   IDLE/DONE + start: next edge x <= init_val, init_val_chk <= init_val_chk+1, step_cnt <= 0,
//    fixed <= 0, timeout <= 0, state <= LOAD. Without start, all outputs hold; DONE is held indefinitely.
//   LOAD: one cycle; x held, busy=1. Lets the checker register the new x. -> RUN.
//   RUN, checked in priority order each cycle:
//    1. fp_flag=1 and step_cnt >= 2: -> DONE, fixed <= 1, x and step_cnt hold.
//    2. else step_cnt == MAX_STEPS: -> DONE, timeout <= 1, x holds.
//    3. else: x <= F(x), step_cnt <= step_cnt+1.
//   fp_flag with step_cnt < 2 is stale from the previous run and is ignored.
//  start while busy: ignored; the run tag does not change.
//  start in the same cycle as rst: reset wins.
//  fixed and timeout are mutually exclusive. Both hold through DONE and clear on the next accepted start.
//  init_val_chk wraps 255 -> 0. It changes on every accepted start, even when init_val is the same
//   as the previous run, so the checker always sees a new tag.
//  Checker timing: x changes only at LOAD entry and in RUN. In DONE, x is frozen, so fp_flag stays
//   asserted.
// TESTING
//  1 Default masks, start with init_val=8'h00 -> done=1, fixed=1, timeout=0, x=8'h00, step_cnt<=3,
//    init_val_chk=1.
//  2 Default masks, init_val=8'h01, MAX_STEPS=16 -> x rotates left each RUN cycle (01,02,04,...);
//    then done=1, timeout=1, fixed=0, step_cnt=16, x=8'h01.
//  3 After test 1, start again with the same init_val=8'h00 -> init_val_chk=2; fp_flag asserted during
//    LOAD and step_cnt<2 is ignored; run ends fixed=1.
//  4 Start with init_val=8'h01, then pulse start with init_val=8'hFF at RUN step 3 -> start ignored;
//    init_val_chk unchanged; trajectory continues 08,10,...
//  5 rst asserted at RUN step 5 -> next edge: IDLE, x=0, init_val_chk=0, busy=done=fixed=timeout=0,
//    step_cnt=0.
//  6 INH_MASK gene0 = 8'h02, ACT gene0 = 8'h80, init_val=8'h82 -> x[0] next = 0 (inhibition beats
//    activation).

Source files
------------

// File: rtl/gene_network_stepper.sv
// gene_network_stepper
//   Boolean gene-regulatory-network update engine for an 8-gene network.
//   On an accepted start it loads init_val, waits one cycle so the downstream
//   fixed-point checker can register the new state, then applies
//   x <= F(x) once per clock until the checker reports a fixed point or the
//   step budget is used up.
//
// Ports
//   clk          in   clock, all state changes on posedge
//   rst          in   synchronous active-high reset
//   start        in   run request, accepted only in IDLE or DONE
//   init_val     in   initial gene state, sampled when start is accepted
//   fp_flag      in   fixed-point flag from the downstream checker
//   x            out  current gene state (registered)
//   init_val_chk out  run tag, +1 (mod 256) on every accepted start
//   busy         out  high in LOAD or RUN
//   done         out  high in DONE
//   fixed        out  last run ended on a qualified fp_flag
//   timeout      out  last run ended on the step budget
//   step_cnt     out  updates applied in the current/last run

// One gene's update rule: on if any activator is on and no inhibitor is on.
module gene_cell #(
    parameter logic [7:0] ACT = 8'h00,
    parameter logic [7:0] INH = 8'h00
) (
    input  logic [7:0] x,
    output logic       nxt
);
    assign nxt = (|(x & ACT)) & ~(|(x & INH));
endmodule

module gene_network_stepper #(
    parameter logic [63:0] ACT_MASK  = 64'h4020100804020180,
    parameter logic [63:0] INH_MASK  = 64'h0,
    parameter int          STEP_W    = 8,
    parameter int          MAX_STEPS = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        init_val,
    input  logic              fp_flag,
    output logic [7:0]        x,
    output logic [7:0]        init_val_chk,
    output logic              busy,
    output logic              done,
    output logic              fixed,
    output logic              timeout,
    output logic [STEP_W-1:0] step_cnt
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t            state, state_n;
    logic [7:0]        f_x;
    logic [7:0]        x_n, tag_n;
    logic [STEP_W-1:0] cnt_n;
    logic              fixed_n, to_n;

    // Network function F: one cell per gene, masks sliced per byte.
    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_gene
            gene_cell #(
                .ACT(ACT_MASK[8*g +: 8]),
                .INH(INH_MASK[8*g +: 8])
            ) u_cell (
                .x  (x),
                .nxt(f_x[g])
            );
        end
    endgenerate

    assign busy = (state == LOAD) || (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        state_n = state;
        x_n     = x;
        tag_n   = init_val_chk;
        cnt_n   = step_cnt;
        fixed_n = fixed;
        to_n    = timeout;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = LOAD;
                    x_n     = init_val;
                    tag_n   = init_val_chk + 8'd1;
                    cnt_n   = '0;
                    fixed_n = 1'b0;
                    to_n    = 1'b0;
                end
            end
            LOAD: state_n = RUN;  // x held so the checker registers it
            RUN: begin
                // fp_flag before two updates still reflects the previous run.
                if (fp_flag && (step_cnt >= STEP_W'(2))) begin
                    state_n = DONE;
                    fixed_n = 1'b1;
                end else if (step_cnt == STEP_W'(MAX_STEPS)) begin
                    state_n = DONE;
                    to_n    = 1'b1;
                end else begin
                    x_n   = f_x;
                    cnt_n = step_cnt + STEP_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            x            <= '0;
            init_val_chk <= '0;
            step_cnt     <= '0;
            fixed        <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= state_n;
            x            <= x_n;
            init_val_chk <= tag_n;
            step_cnt     <= cnt_n;
            fixed        <= fixed_n;
            timeout      <= to_n;
        end
    end
endmodule
